// File: rtl/dummy_alg_pkg.sv
// rtl/dummy_alg_pkg.sv - shared constants and FSM state type for the dummy matrix compute engine
package dummy_alg_pkg;

  localparam int N      = 32;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 5;
  localparam int ACC_W  = 21;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    MAC,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - sequential dot product, one unsigned multiply-accumulate per cycle
module dot_product_mac
  import dummy_alg_pkg::*;
#(
  parameter int VEC_N = N,
  parameter int VEC_W = ELEM_W,
  parameter int SUM_W = ACC_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   i_start,
  input  logic [VEC_N*VEC_W-1:0] i_vec_a,
  input  logic [VEC_N*VEC_W-1:0] i_vec_b,
  output logic [SUM_W-1:0]       o_result,
  output logic                   o_valid
);

  localparam int KW = $clog2(VEC_N);

  logic [VEC_N*VEC_W-1:0] r_vec_a;
  logic [VEC_N*VEC_W-1:0] r_vec_b;
  logic [SUM_W-1:0]       r_acc;
  logic [KW-1:0]          r_k;
  logic                   r_busy;
  logic [2*VEC_W-1:0]     w_prod;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_last;

  // Operands shift down each cycle so element k is always in the low lane.
  assign w_prod   = r_vec_a[VEC_W-1:0] * r_vec_b[VEC_W-1:0];
  assign w_sum    = r_acc + SUM_W'(w_prod);
  assign w_last   = r_busy && (r_k == KW'(VEC_N - 1));
  assign o_result = w_sum;
  assign o_valid  = w_last;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_vec_a <= '0;
      r_vec_b <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_vec_a <= i_vec_a;
      r_vec_b <= i_vec_b;
      r_acc   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_vec_a <= r_vec_a >> VEC_W;
      r_vec_b <= r_vec_b >> VEC_W;
      r_acc   <= w_sum;
      r_k     <= r_k + KW'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/dummy_alg_core.sv
// rtl/dummy_alg_core.sv - request/compute/stream FSM for C = A x B; DUMMY_ALG_SATURATE_EN clamps results to 0xFF
module dummy_alg_core #(
  parameter int N      = 32,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                complete,
  input  logic [N*ELEM_W-1:0] matA_row,
  input  logic [N*ELEM_W-1:0] matB_col,
  input  logic [ADDR_W-1:0]   row_in,
  input  logic [ADDR_W-1:0]   col_in,
  input  logic                val_rows,
  output logic                new_request,
  output logic [ADDR_W-1:0]   row_req,
  output logic [ADDR_W-1:0]   col_req,
  output logic [ELEM_W-1:0]   matrix_val,
  output logic [ADDR_W-1:0]   row_out,
  output logic [ADDR_W-1:0]   col_out,
  output logic                valid_out,
  output logic                done
);

  import dummy_alg_pkg::*;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_i, r_j, w_i_nxt, w_j_nxt;
  logic                r_new_request, w_new_request_nxt;
  logic [ADDR_W-1:0]   r_row_req, r_col_req, w_row_req_nxt, w_col_req_nxt;
  logic [ELEM_W-1:0]   r_matrix_val, w_matrix_val_nxt;
  logic [ADDR_W-1:0]   r_row_out, r_col_out, w_row_out_nxt, w_col_out_nxt;
  logic                r_valid_out, w_valid_out_nxt;
  logic                r_done, w_done_nxt;
  logic                w_mac_start;
  logic                w_mac_valid;
  logic [ACC_W-1:0]    w_mac_result;
  logic [ELEM_W-1:0]   w_elem;
  logic                w_match;
  logic                w_last_elem;

  dot_product_mac #(
    .VEC_N (N),
    .VEC_W (ELEM_W),
    .SUM_W (ACC_W)
  ) u_mac (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .i_start  (w_mac_start),
    .i_vec_a  (matA_row),
    .i_vec_b  (matB_col),
    .o_result (w_mac_result),
    .o_valid  (w_mac_valid)
  );

`ifdef DUMMY_ALG_SATURATE_EN
  assign w_elem = (w_mac_result > ACC_W'((1 << ELEM_W) - 1)) ? {ELEM_W{1'b1}} : ELEM_W'(w_mac_result);
`else
  assign w_elem = ELEM_W'(w_mac_result);
`endif

  assign w_match     = val_rows && (row_in == r_i) && (col_in == r_j);
  assign w_last_elem = (r_i == ADDR_W'(N - 1)) && (r_j == ADDR_W'(N - 1));

  always_comb begin
    w_state_nxt       = r_state;
    w_i_nxt           = r_i;
    w_j_nxt           = r_j;
    w_new_request_nxt = 1'b0;
    w_row_req_nxt     = r_row_req;
    w_col_req_nxt     = r_col_req;
    w_matrix_val_nxt  = r_matrix_val;
    w_row_out_nxt     = r_row_out;
    w_col_out_nxt     = r_col_out;
    w_valid_out_nxt   = 1'b0;
    w_done_nxt        = r_done;
    w_mac_start       = 1'b0;
    case (r_state)
      IDLE: if (complete) begin
        w_state_nxt       = REQ;
        w_new_request_nxt = 1'b1;
        w_row_req_nxt     = r_i;
        w_col_req_nxt     = r_j;
      end
      REQ: w_state_nxt = WAIT;
      WAIT: if (w_match) begin
        w_mac_start = 1'b1;
        w_state_nxt = MAC;
      end
      MAC: if (w_mac_valid) begin
        w_state_nxt      = OUT;
        w_valid_out_nxt  = 1'b1;
        w_matrix_val_nxt = w_elem;
        w_row_out_nxt    = r_i;
        w_col_out_nxt    = r_j;
      end
      OUT: begin
        if (w_last_elem) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          // Row-major walk: column index wraps into the next row.
          w_j_nxt = r_j + ADDR_W'(1);
          if (r_j == ADDR_W'(N - 1)) w_i_nxt = r_i + ADDR_W'(1);
          w_state_nxt       = REQ;
          w_new_request_nxt = 1'b1;
          w_row_req_nxt     = w_i_nxt;
          w_col_req_nxt     = w_j_nxt;
        end
      end
      DONE: w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_new_request <= 1'b0;
      r_row_req     <= '0;
      r_col_req     <= '0;
      r_matrix_val  <= '0;
      r_row_out     <= '0;
      r_col_out     <= '0;
      r_valid_out   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_new_request <= w_new_request_nxt;
      r_row_req     <= w_row_req_nxt;
      r_col_req     <= w_col_req_nxt;
      r_matrix_val  <= w_matrix_val_nxt;
      r_row_out     <= w_row_out_nxt;
      r_col_out     <= w_col_out_nxt;
      r_valid_out   <= w_valid_out_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign new_request = r_new_request;
  assign row_req     = r_row_req;
  assign col_req     = r_col_req;
  assign matrix_val  = r_matrix_val;
  assign row_out     = r_row_out;
  assign col_out     = r_col_out;
  assign valid_out   = r_valid_out;
  assign done        = r_done;

endmodule

// File: tb/tb_dummy_alg_core.sv
// tb/tb_dummy_alg_core.sv - directed self-checking bench for dummy_alg_core
module tb_dummy_alg_core;
  import dummy_alg_pkg::*;

  localparam int VW = N * ELEM_W;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              complete;
  logic [VW-1:0]     matA_row;
  logic [VW-1:0]     matB_col;
  logic [ADDR_W-1:0] row_in;
  logic [ADDR_W-1:0] col_in;
  logic              val_rows;
  logic              new_request;
  logic [ADDR_W-1:0] row_req;
  logic [ADDR_W-1:0] col_req;
  logic [ELEM_W-1:0] matrix_val;
  logic [ADDR_W-1:0] row_out;
  logic [ADDR_W-1:0] col_out;
  logic              valid_out;
  logic              done;

  int checks = 0;
  int errors = 0;
  int nreq_cnt = 0;
  int vout_cnt = 0;

  dummy_alg_core #(.N(N), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .complete    (complete),
    .matA_row    (matA_row),
    .matB_col    (matB_col),
    .row_in      (row_in),
    .col_in      (col_in),
    .val_rows    (val_rows),
    .new_request (new_request),
    .row_req     (row_req),
    .col_req     (col_req),
    .matrix_val  (matrix_val),
    .row_out     (row_out),
    .col_out     (col_out),
    .valid_out   (valid_out),
    .done        (done)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (new_request === 1'b1) nreq_cnt++;
    if (valid_out === 1'b1) vout_cnt++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] a_row(input int i);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*ELEM_W +: ELEM_W] = (k == i) ? 8'h00 : 8'hFF;
    return v;
  endfunction

  function automatic logic [VW-1:0] b_col(input int j);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*ELEM_W +: ELEM_W] = (k == j) ? 8'hFF : 8'h00;
    return v;
  endfunction

  function automatic logic [7:0] exp_val(input int i, input int j);
`ifdef DUMMY_ALG_SATURATE_EN
    return (i == j) ? 8'h00 : 8'hFF;
`else
    return (i == j) ? 8'h00 : 8'h01;
`endif
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_new_request"}, new_request, 0);
    check({tag, "_row_req"}, row_req, 0);
    check({tag, "_col_req"}, col_req, 0);
    check({tag, "_matrix_val"}, matrix_val, 0);
    check({tag, "_row_out"}, row_out, 0);
    check({tag, "_col_out"}, col_out, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic wait_req();
    int lat = 0;
    while (new_request !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check("req_seen", new_request, 1);
  endtask

  task automatic drive(input int i, input int j, input logic [VW-1:0] a, input logic [VW-1:0] b);
    val_rows = 1'b1;
    row_in   = ADDR_W'(i);
    col_in   = ADDR_W'(j);
    matA_row = a;
    matB_col = b;
    tick();
    val_rows = 1'b0;
  endtask

  task automatic serve(input int i, input int j, input bit mism);
    int lat;
    logic [VW-1:0] ones;
    wait_req();
    check("row_req", row_req, i);
    check("col_req", col_req, j);
    check("req_vs_valid", valid_out, 0);
    tick();
    check("req_one_cycle", new_request, 0);
    if (mism) begin
      for (int k = 0; k < N; k++) ones[k*ELEM_W +: ELEM_W] = 8'h01;
      drive(i, j + 1, ones, ones);
    end
    drive(i, j, a_row(i), b_col(j));
    lat = 1;
    while (valid_out !== 1'b1 && lat < 45) begin
      tick();
      lat++;
    end
    check("valid_latency", lat, 33);
    check("matrix_val", matrix_val, exp_val(i, j));
    check("row_out", row_out, i);
    check("col_out", col_out, j);
    check("valid_vs_req", new_request, 0);
    tick();
    check("valid_one_cycle", valid_out, 0);
    if (i == N - 1 && j == N - 1) begin
      check("done_after_last", done, 1);
      check("no_req_after_last", new_request, 0);
    end else begin
      check("done_low", done, 0);
      check("next_req_t34", new_request, 1);
    end
  endtask

  initial begin
    int snap_req;
    int snap_vout;
    rst_in   = 1'b1;
    complete = 1'b0;
    val_rows = 1'b0;
    row_in   = '0;
    col_in   = '0;
    matA_row = '0;
    matB_col = '0;

    repeat (2) tick();
    rst_in = 1'b0;
    check_zero("reset");
    snap_req = nreq_cnt;
    repeat (100) tick();
    check("idle_no_request", nreq_cnt - snap_req, 0);
    check_zero("idle");

    snap_req  = nreq_cnt;
    snap_vout = vout_cnt;
    complete = 1'b1;
    tick();
    complete = 1'b0;
    check("complete_to_req", new_request, 1);
    for (int idx = 0; idx < N * N; idx++) begin
      serve(idx / N, idx % N, (idx == 3 * N + 7));
    end
    check("req_total", nreq_cnt - snap_req, 1024);
    check("valid_total", vout_cnt - snap_vout, 1024);
    complete = 1'b1;
    repeat (50) tick();
    complete = 1'b0;
    check("done_sticky", done, 1);
    check("done_no_more_req", nreq_cnt - snap_req, 1024);
    check("done_no_more_valid", vout_cnt - snap_vout, 1024);

    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_zero("reset2");
    complete = 1'b1;
    tick();
    complete = 1'b0;
    for (int idx = 0; idx < 5 * N + 5; idx++) serve(idx / N, idx % N, 1'b0);
    wait_req();
    check("mid_row_req", row_req, 5);
    check("mid_col_req", col_req, 5);
    tick();
    drive(5, 5, a_row(5), b_col(5));
    repeat (10) tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check_zero("reset_mid");
    snap_req  = nreq_cnt;
    snap_vout = vout_cnt;
    repeat (40) tick();
    check("mid_abort_valid", vout_cnt - snap_vout, 0);
    check("mid_abort_req", nreq_cnt - snap_req, 0);
    complete = 1'b1;
    tick();
    complete = 1'b0;
    check("restart_req", new_request, 1);
    check("restart_row", row_req, 0);
    check("restart_col", col_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
